exc_ctrl: RTL and testbench

- Exception/interrupt arbiter between the MEM stage and the CP0 register file.
- Collects per-instruction exception flags from MEM, samples external interrupts, and owns the Count/Compare timer.
- Picks the highest-priority event each cycle and emits a single-cycle CP0 update bundle plus a pipeline flush with redirect PC.
- Handles ERET redirect to EPC.

---
 rtl/exc_pkg.sv | 35 +++
 rtl/exc_ctrl_cp0_timer.sv | 54 +++++
 rtl/exc_ctrl.sv | 135 +++++++++++++
 tb/tb_exc_ctrl.sv | 230 +++++++++++++++++++++++
 4 files changed

// File: rtl/exc_pkg.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | Module  : exc_pkg                                                     |
// | Brief   : Shared ExcCodes, mem_exc bit positions and FSM encoding     |
// |           for the exception/interrupt arbiter.                        |
// | Rev     : 1.0  initial release                                        |
// +-----------------------------------------------------------------------+
package exc_pkg;

  // Cause.ExcCode values
  localparam logic [4:0] EXC_INT  = 5'd0;
  localparam logic [4:0] EXC_ADEL = 5'd4;
  localparam logic [4:0] EXC_ADES = 5'd5;
  localparam logic [4:0] EXC_SYS  = 5'd8;
  localparam logic [4:0] EXC_BP   = 5'd9;
  localparam logic [4:0] EXC_RI   = 5'd10;
  localparam logic [4:0] EXC_OV   = 5'd12;

  // Bit positions inside mem_exc = {adel_if, ri, ov, sys, bp, adel, ades}
  localparam int EXB_ADES    = 0;
  localparam int EXB_ADEL    = 1;
  localparam int EXB_BP      = 2;
  localparam int EXB_SYS     = 3;
  localparam int EXB_OV      = 4;
  localparam int EXB_RI      = 5;
  localparam int EXB_ADEL_IF = 6;

  // Arbiter state: SETTLE blocks commits while the CP0 write lands
  typedef enum logic [0:0] {
    ST_IDLE   = 1'b0,
    ST_SETTLE = 1'b1
  } exc_state_t;

endpackage
`default_nettype wire

// File: rtl/exc_ctrl_cp0_timer.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | Module  : cp0_timer                                                   |
// | Brief   : CP0 Count/Compare pair. Count advances every second clock;  |
// |           ti is a sticky match flag cleared by a Compare write.       |
// | Rev     : 1.0  initial release                                        |
// +-----------------------------------------------------------------------+
module cp0_timer (
  input  logic        clk,
  input  logic        resetn,
  input  logic        tmr_we_count,
  input  logic        tmr_we_compare,
  input  logic [31:0] tmr_wdata,
  output logic [31:0] count,
  output logic [31:0] compare,
  output logic        ti
);

  logic [31:0] r_count;
  logic [31:0] r_compare;
  logic        r_tog;
  logic        r_ti;

  // Count/Compare update, half-rate toggle and sticky match flag
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_count   <= '0;
      r_compare <= '0;
      r_tog     <= 1'b0;
      r_ti      <= 1'b0;
    end else begin
      // A software Count write overrides the increment and restarts the phase
      if (tmr_we_count) begin
        r_count <= tmr_wdata;
        r_tog   <= 1'b0;
      end else begin
        r_tog <= ~r_tog;
        if (r_tog) r_count <= r_count + 32'd1;
      end

      if (tmr_we_compare) r_compare <= tmr_wdata;

      // Compare write acknowledges the interrupt and beats a same-cycle match
      if (tmr_we_compare)            r_ti <= 1'b0;
      else if (r_count == r_compare) r_ti <= 1'b1;
    end
  end

  assign count   = r_count;
  assign compare = r_compare;
  assign ti      = r_ti;

endmodule
`default_nettype wire

// File: rtl/exc_ctrl.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | Module  : exc_ctrl                                                    |
// | Brief   : Exception/interrupt arbiter between MEM and CP0. Selects    |
// |           the highest-priority event, emits the CP0 update bundle,    |
// |           flush and redirect PC; handles ERET and the CP0 timer.      |
// | Rev     : 1.0  initial release                                        |
// +-----------------------------------------------------------------------+
module exc_ctrl
  import exc_pkg::*;
#(
  parameter logic [31:0] EXC_VECTOR  = 32'hBFC00380,
  parameter int          SYNC_STAGES = 2
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        mem_valid,
  input  logic        mem_stall,
  input  logic [31:0] mem_pc,
  input  logic        mem_bd,
  input  logic [6:0]  mem_exc,
  input  logic        mem_eret,
  input  logic [31:0] mem_badvaddr,
  input  logic [5:0]  ext_int,
  input  logic        st_ie,
  input  logic        st_exl,
  input  logic [7:0]  st_im,
  input  logic [1:0]  cause_ip_sw,
  input  logic [31:0] cp0_epc,
  input  logic        tmr_we_count,
  input  logic        tmr_we_compare,
  input  logic [31:0] tmr_wdata,
  output logic        flush,
  output logic [31:0] flush_pc,
  output logic        upd_en,
  output logic [4:0]  upd_exccode,
  output logic        upd_bd,
  output logic [31:0] upd_epc,
  output logic        upd_bva_en,
  output logic [31:0] upd_bva,
  output logic        upd_eret,
  output logic [5:0]  hw_ip,
  output logic [31:0] count,
  output logic [31:0] compare
);

  logic [SYNC_STAGES-1:0][5:0] r_sync;
  exc_state_t                  r_state;
  logic                        w_ti;
  logic                        w_int_req;
  logic                        w_take;
  logic                        w_exc;
  logic [4:0]                  w_code;
  logic                        w_bva_en;
  logic [31:0]                 w_bva;

  cp0_timer u_timer (
    .clk            (clk),
    .resetn         (resetn),
    .tmr_we_count   (tmr_we_count),
    .tmr_we_compare (tmr_we_compare),
    .tmr_wdata      (tmr_wdata),
    .count          (count),
    .compare        (compare),
    .ti             (w_ti)
  );

  // Multi-flop synchronizer for the asynchronous interrupt lines
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) r_sync <= '0;
    else         r_sync <= {r_sync[SYNC_STAGES-2:0], ext_int};
  end

  // Timer interrupt shares the top hardware line
  assign hw_ip = {r_sync[SYNC_STAGES-1][5] | w_ti, r_sync[SYNC_STAGES-1][4:0]};

  assign w_int_req = st_ie & ~st_exl & (|({hw_ip, cause_ip_sw} & st_im));

  // resetn gating keeps every strobe low while reset is held
  assign w_take = resetn & mem_valid & ~mem_stall & (r_state == ST_IDLE);

  // Priority encoder: interrupt first, then instruction exceptions in order
  always_comb begin
    w_exc    = 1'b1;
    w_code   = EXC_INT;
    w_bva_en = 1'b0;
    w_bva    = '0;
    if (w_int_req) begin
      w_code = EXC_INT;
    end else if (mem_exc[EXB_ADEL_IF]) begin
      w_code   = EXC_ADEL;
      w_bva_en = 1'b1;
      w_bva    = mem_pc;
    end else if (mem_exc[EXB_RI]) begin
      w_code = EXC_RI;
    end else if (mem_exc[EXB_OV]) begin
      w_code = EXC_OV;
    end else if (mem_exc[EXB_SYS]) begin
      w_code = EXC_SYS;
    end else if (mem_exc[EXB_BP]) begin
      w_code = EXC_BP;
    end else if (mem_exc[EXB_ADEL]) begin
      w_code   = EXC_ADEL;
      w_bva_en = 1'b1;
      w_bva    = mem_badvaddr;
    end else if (mem_exc[EXB_ADES]) begin
      w_code   = EXC_ADES;
      w_bva_en = 1'b1;
      w_bva    = mem_badvaddr;
    end else begin
      w_exc = 1'b0;
    end
  end

  assign upd_en      = w_take & w_exc;
  assign upd_eret    = w_take & ~w_exc & mem_eret;
  assign flush       = upd_en | upd_eret;
  assign flush_pc    = upd_en ? EXC_VECTOR : (upd_eret ? cp0_epc : '0);
  assign upd_exccode = upd_en ? w_code : '0;
  assign upd_bd      = upd_en & mem_bd;
  // A delay-slot fault restarts at the branch so the branch re-executes
  assign upd_epc     = upd_en ? (mem_bd ? mem_pc - 32'd4 : mem_pc) : '0;
  assign upd_bva_en  = upd_en & w_bva_en;
  assign upd_bva     = upd_bva_en ? w_bva : '0;

  // One-cycle settle after every redirect so stale Status is never sampled
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn)                          r_state <= ST_IDLE;
    else if (r_state == ST_SETTLE)        r_state <= ST_IDLE;
    else if (flush)                       r_state <= ST_SETTLE;
    else                                  r_state <= ST_IDLE;
  end

endmodule
`default_nettype wire

// File: tb/tb_exc_ctrl.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | Module  : tb_exc_ctrl                                                 |
// | Brief   : Directed self-checking bench for exc_ctrl.                  |
// | Rev     : 1.0  initial release                                        |
// +-----------------------------------------------------------------------+
module tb_exc_ctrl;

  logic        clk = 1'b0;
  logic        resetn;
  logic        mem_valid, mem_stall, mem_bd, mem_eret;
  logic [31:0] mem_pc, mem_badvaddr, cp0_epc, tmr_wdata;
  logic [6:0]  mem_exc;
  logic [5:0]  ext_int;
  logic        st_ie, st_exl;
  logic [7:0]  st_im;
  logic [1:0]  cause_ip_sw;
  logic        tmr_we_count, tmr_we_compare;
  logic        flush, upd_en, upd_bd, upd_bva_en, upd_eret;
  logic [31:0] flush_pc, upd_epc, upd_bva, count, compare;
  logic [4:0]  upd_exccode;
  logic [5:0]  hw_ip;

  int n_vec = 0;
  int n_err = 0;
  int guard;

  exc_ctrl dut (
    .clk            (clk),
    .resetn         (resetn),
    .mem_valid      (mem_valid),
    .mem_stall      (mem_stall),
    .mem_pc         (mem_pc),
    .mem_bd         (mem_bd),
    .mem_exc        (mem_exc),
    .mem_eret       (mem_eret),
    .mem_badvaddr   (mem_badvaddr),
    .ext_int        (ext_int),
    .st_ie          (st_ie),
    .st_exl         (st_exl),
    .st_im          (st_im),
    .cause_ip_sw    (cause_ip_sw),
    .cp0_epc        (cp0_epc),
    .tmr_we_count   (tmr_we_count),
    .tmr_we_compare (tmr_we_compare),
    .tmr_wdata      (tmr_wdata),
    .flush          (flush),
    .flush_pc       (flush_pc),
    .upd_en         (upd_en),
    .upd_exccode    (upd_exccode),
    .upd_bd         (upd_bd),
    .upd_epc        (upd_epc),
    .upd_bva_en     (upd_bva_en),
    .upd_bva        (upd_bva),
    .upd_eret       (upd_eret),
    .hw_ip          (hw_ip),
    .count          (count),
    .compare        (compare)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Inputs change on the falling edge; outputs are sampled 2 ns later
  task automatic next_cycle();
    @(negedge clk);
    #2;
  endtask

  task automatic strobes_zero(input string tag);
    check({tag, "_upd_en"}, {31'd0, upd_en}, 32'd0);
    check({tag, "_flush"},  {31'd0, flush},  32'd0);
    check({tag, "_eret"},   {31'd0, upd_eret}, 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    resetn = 1'b0; mem_valid = 1'b0; mem_stall = 1'b0; mem_pc = '0; mem_bd = 1'b0;
    mem_exc = '0; mem_eret = 1'b0; mem_badvaddr = '0; ext_int = '0; st_ie = 1'b0;
    st_exl = 1'b0; st_im = '0; cause_ip_sw = '0; cp0_epc = '0;
    tmr_we_count = 1'b0; tmr_we_compare = 1'b0; tmr_wdata = '0;

    // Reset values
    repeat (3) next_cycle();
    strobes_zero("rst");
    check("rst_count",   count,   32'd0);
    check("rst_compare", compare, 32'd0);
    check("rst_hw_ip",   {26'd0, hw_ip}, 32'd0);
    check("rst_fpc",     flush_pc, 32'd0);
    @(negedge clk);
    resetn = 1'b1;

    // 1: ten idle edges -> count 5
    repeat (10) @(posedge clk);
    @(negedge clk); #2;
    check("idle_count", count, 32'd5);
    strobes_zero("idle");
    check("idle_bva_en", {31'd0, upd_bva_en}, 32'd0);

    // 2: overflow in a delay slot
    mem_valid = 1'b1; mem_pc = 32'h80001000; mem_bd = 1'b1; mem_exc = 7'b0010000;
    #1;
    check("ov_upd_en", {31'd0, upd_en}, 32'd1);
    check("ov_code",   {27'd0, upd_exccode}, 32'd12);
    check("ov_epc",    upd_epc, 32'h80000FFC);
    check("ov_bd",     {31'd0, upd_bd}, 32'd1);
    check("ov_fpc",    flush_pc, 32'hBFC00380);
    check("ov_flush",  {31'd0, flush}, 32'd1);
    check("ov_bva_en", {31'd0, upd_bva_en}, 32'd0);
    next_cycle();
    strobes_zero("ov_settle");
    mem_valid = 1'b0;

    // 3: ri beats ades; then ades alone
    next_cycle();
    mem_valid = 1'b1; mem_bd = 1'b0; mem_pc = 32'h80001100;
    mem_exc = 7'b0100001; mem_badvaddr = 32'h00001003;
    #1;
    check("ri_code",   {27'd0, upd_exccode}, 32'd10);
    check("ri_bva_en", {31'd0, upd_bva_en}, 32'd0);
    check("ri_epc",    upd_epc, 32'h80001100);
    next_cycle();
    mem_valid = 1'b0;
    next_cycle();
    mem_valid = 1'b1; mem_exc = 7'b0000001;
    #1;
    check("ades_code",   {27'd0, upd_exccode}, 32'd5);
    check("ades_bva_en", {31'd0, upd_bva_en}, 32'd1);
    check("ades_bva",    upd_bva, 32'h00001003);
    next_cycle();
    mem_valid = 1'b0; mem_exc = '0;

    // 4: timer interrupt at count==compare==6
    next_cycle();
    tmr_we_count = 1'b1; tmr_wdata = 32'd0;
    next_cycle();
    tmr_we_count = 1'b0; tmr_we_compare = 1'b1; tmr_wdata = 32'd6;
    next_cycle();
    tmr_we_compare = 1'b0;
    check("tmr_ti_clr", {31'd0, hw_ip[5]}, 32'd0);
    check("tmr_cmp",    compare, 32'd6);
    st_ie = 1'b1; st_im = 8'h80; mem_valid = 1'b1; mem_pc = 32'h80003000;
    #1;
    guard = 0;
    while (!upd_en && guard < 40) begin
      next_cycle();
      guard++;
    end
    check("tmr_int_taken", {31'd0, upd_en}, 32'd1);
    check("tmr_latency",   guard, 32'd12);
    check("tmr_code",      {27'd0, upd_exccode}, 32'd0);
    check("tmr_count",     count, 32'd6);
    check("tmr_hw_ip5",    {31'd0, hw_ip[5]}, 32'd1);
    check("tmr_epc",       upd_epc, 32'h80003000);
    next_cycle();
    mem_valid = 1'b0; st_ie = 1'b0;
    tmr_we_compare = 1'b1; tmr_wdata = 32'hFFFFFFF0;
    next_cycle();
    tmr_we_compare = 1'b0;
    check("tmr_ack", {31'd0, hw_ip[5]}, 32'd0);

    // 5: external interrupt masked by EXL, then taken
    st_ie = 1'b1; st_exl = 1'b1; st_im = 8'h04; mem_valid = 1'b1; mem_pc = 32'h80004000;
    ext_int = 6'b000001;
    next_cycle();
    check("ext_sync1", {26'd0, hw_ip}, 32'd0);
    check("ext_exl1",  {31'd0, upd_en}, 32'd0);
    next_cycle();
    check("ext_sync2", {26'd0, hw_ip}, 32'd1);
    check("ext_exl2",  {31'd0, upd_en}, 32'd0);
    next_cycle();
    st_exl = 1'b0;
    #1;
    check("ext_taken", {31'd0, upd_en}, 32'd1);
    check("ext_code",  {27'd0, upd_exccode}, 32'd0);
    next_cycle();
    mem_valid = 1'b0; ext_int = '0; st_ie = 1'b0; st_im = '0;

    // 6: ERET, then ERET held off by a stall
    next_cycle();
    mem_valid = 1'b1; mem_eret = 1'b1; cp0_epc = 32'h80002000;
    #1;
    check("eret_strobe", {31'd0, upd_eret}, 32'd1);
    check("eret_flush",  {31'd0, flush}, 32'd1);
    check("eret_fpc",    flush_pc, 32'h80002000);
    check("eret_upd_en", {31'd0, upd_en}, 32'd0);
    next_cycle();
    mem_valid = 1'b0;
    next_cycle();
    mem_valid = 1'b1; mem_stall = 1'b1;
    #1;
    strobes_zero("stall1");
    next_cycle();
    strobes_zero("stall2");
    mem_stall = 1'b0;
    #1;
    check("unstall_eret", {31'd0, upd_eret}, 32'd1);
    check("unstall_fpc",  flush_pc, 32'h80002000);
    next_cycle();
    mem_valid = 1'b0; mem_eret = 1'b0;

    // Reset mid-operation: strobes stay low and timer clears at once
    next_cycle();
    mem_valid = 1'b1; mem_exc = 7'b0010000; resetn = 1'b0;
    #1;
    strobes_zero("arst");
    check("arst_count",   count, 32'd0);
    check("arst_compare", compare, 32'd0);
    next_cycle();
    strobes_zero("arst_hold");
    mem_valid = 1'b0; mem_exc = '0;

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire
